axi_lite_master_slave: RTL and testbench
========================================

Name: axi_lite_master_slave

Overview:
- Self-contained AXI4-Lite subsystem: a single-outstanding master FSM drives an internal AXI-Lite link into a slave register memory.
- A user issues single-cycle write or read requests. The block performs the full AW/W/B or AR/R handshake internally.
- Channel signals are exported for observation.
- Used as a bus bring-up and verification vehicle.

Parameters:
- DEPTH, 16, number of 32-bit words in slave memory; power of two, ≥2.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridable.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-low reset.
- valid  in  1  write request strobe; one-cycle pulse.
- read_valid  in  1  read request strobe; one-cycle pulse.
- aw_addr  in  32  write word address.
- w_data  in  32  write data.
- w_strb  in  4  write byte strobes; bit i enables byte lane i (bits 8i+7:8i).
- ar_addr  in  32  read word address.
- ready  out  1  master idle; a new request is accepted.
- AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY  out  1 each  internal channel handshakes.
- AWADDR, WDATA, ARADDR  out  32  internal channel payloads.
- WSTRB  out  4  internal write strobes.
- BRESP, RRESP  out  2  responses: 00 = OKAY, 10 = SLVERR.
- RDATA  out  32  read data.

Behaviour:
- Reset (ARESET=0, asynchronous):
  - All VALID/READY outputs are 0; ready=1.
  - Payload registers, BRESP, RRESP and RDATA are 0.
  - Memory is cleared to 0.
  - Master FSM goes to IDLE; slave FSMs go to idle.
  - Reset asserted mid-transaction abandons the transaction; no partial memory write occurs after reset asserts.
- Addressing: word address; index = addr[IDX_W-1:0].
- Master FSM:
  - States: IDLE, WADDR, WRESP, RADDR, RDATA.
  - IDLE: ready=1. Requests are sampled at the rising edge.
    - valid=1: latch aw_addr, w_data, w_strb into AWADDR, WDATA, WSTRB. Assert AWVALID=WVALID=1; go to WADDR.
    - Otherwise read_valid=1: latch ar_addr into ARADDR. Assert ARVALID=1; go to RADDR.
    - valid has priority when both are high; that read_valid is dropped.
    - Requests arriving outside IDLE are ignored.
  - WADDR: AWVALID and WVALID each drop at their own handshake edge. Once both handshakes have completed, assert BREADY=1 and go to WRESP.
  - WRESP: on BVALID&BREADY, drop BREADY and return to IDLE.
  - RADDR: drop ARVALID at handshake; assert RREADY=1; go to RDATA.
  - RDATA: on RVALID&RREADY, drop RREADY and return to IDLE.
  - Payloads stay stable while their VALID is high.
- Slave write:
  - When AWVALID&WVALID are high and no response is pending, assert AWREADY=WREADY=1 for exactly one cycle.
  - At the handshake edge:
    - Memory byte lanes with WSTRB=1 update.
    - Lanes with WSTRB=0 keep their value.
    - WSTRB=0000 writes nothing but still responds.
  - BVALID=1 with BRESP is set on that same edge and held until BVALID&BREADY.
- Slave read:
  - When ARVALID is high and no read response is pending, assert ARREADY=1 for one cycle.
  - At the handshake edge, register RDATA=mem[index] and RRESP, and set RVALID=1.
  - RVALID is held until RVALID&RREADY; RDATA is stable meanwhile.
- Latency, from the request-sampling edge N:
  - AWVALID/WVALID high after N; AWREADY/WREADY high after N+1; handshake and memory write at N+2.
  - BVALID high after N+2; B handshake at N+3; ready=1 after N+3.
  - Reads follow the same timing: RVALID/RDATA are valid after N+2.
- A read issued after a write completes returns the written data.

Optional Feature:
- Macro: AXI_ADDR_CHECK_EN.
- Defined: addresses with any bit set at or above IDX_W are out of range.
  - Out-of-range write: no memory change; BRESP=10.
  - Out-of-range read: RDATA=0; RRESP=10.
  - The handshakes otherwise proceed unchanged.
- Undefined: upper address bits are ignored (address wraps modulo DEPTH), and responses are always 00.

Test Plan:
- Reset for 20 ns, then write addr 0, data 12345678, strb 0001 -> BRESP=00; a read of addr 0 returns 00000078; ready returns 1 four cycles after the request.
- Write addr 1 strb 0011, addr 3 strb 1101, addr 7 strb 1111, all with data 12345678 -> reads return 00005678, 12340078, 12345678; RRESP=00.
- Assert valid and read_valid in the same cycle -> only the write executes; ARVALID stays 0.
- Pulse valid while a transaction is in progress -> the pulse is ignored; the memory is unchanged by it.
- With AXI_ADDR_CHECK_EN, write addr 20 -> BRESP=10 and memory unchanged; read addr 20 -> RDATA=0, RRESP=10. Without the macro, the same write lands at index 4 with BRESP=00.
- Assert ARESET low while BVALID=1 -> all VALID/READY go to 0 immediately, ready=1, and memory reads back 0 after reset.

Source files
------------

// File: rtl/axi_lite_master_slave.sv
// axi_lite_master_slave: single-outstanding AXI4-Lite master FSM driving an internal slave register memory.
// Optional macro AXI_ADDR_CHECK_EN: out-of-range addresses get SLVERR instead of wrapping modulo DEPTH.
`default_nettype none

module axi_lite_master_slave #(
    parameter int DEPTH = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        valid,
    input  logic        read_valid,
    input  logic [31:0] aw_addr,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic [31:0] ar_addr,
    output logic        ready,
    output logic        AWVALID,
    output logic        AWREADY,
    output logic        WVALID,
    output logic        WREADY,
    output logic        BVALID,
    output logic        BREADY,
    output logic        ARVALID,
    output logic        ARREADY,
    output logic        RVALID,
    output logic        RREADY,
    output logic [31:0] AWADDR,
    output logic [31:0] WDATA,
    output logic [31:0] ARADDR,
    output logic [3:0]  WSTRB,
    output logic [1:0]  BRESP,
    output logic [1:0]  RRESP,
    output logic [31:0] RDATA
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t      state_q;
    logic        ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] mem_q [DEPTH];

    logic             w_aw_fin, w_w_fin, w_wr_hs, w_rd_hs;
    logic             w_aw_oor, w_ar_oor;
    logic [IDX_W-1:0] w_widx, w_ridx;

    // A channel counts as finished if already dropped or handshaking this cycle.
    assign w_aw_fin = !awvalid_q || awready_q;
    assign w_w_fin  = !wvalid_q  || wready_q;
    assign w_wr_hs  = awvalid_q && awready_q && wvalid_q && wready_q;
    assign w_rd_hs  = arvalid_q && arready_q;
    assign w_widx   = awaddr_q[IDX_W-1:0];
    assign w_ridx   = araddr_q[IDX_W-1:0];

`ifdef AXI_ADDR_CHECK_EN
    assign w_aw_oor = |awaddr_q[31:IDX_W];
    assign w_ar_oor = |araddr_q[31:IDX_W];
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        awaddr_q  <= aw_addr;
                        wdata_q   <= w_data;
                        wstrb_q   <= w_strb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= ST_WADDR;
                    end else if (read_valid) begin
                        araddr_q  <= ar_addr;
                        arvalid_q <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= ST_RADDR;
                    end
                end
                ST_WADDR: begin
                    if (awvalid_q && awready_q) awvalid_q <= 1'b0;
                    if (wvalid_q && wready_q)   wvalid_q  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (bvalid_q && bready_q) begin
                        bready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RADDR: begin
                    if (w_rd_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (rvalid_q && rready_q) begin
                        rready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Slave side: write channel, B response and register memory.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (bvalid_q && bready_q) bvalid_q <= 1'b0;
            if (w_wr_hs) begin
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= w_aw_oor ? 2'b10 : 2'b00;
                if (!w_aw_oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) mem_q[w_widx][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end else if (awvalid_q && wvalid_q && !bvalid_q && !awready_q) begin
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end
        end
    end

    // Slave side: read channel.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            if (rvalid_q && rready_q) rvalid_q <= 1'b0;
            if (w_rd_hs) begin
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= w_ar_oor ? 32'h0 : mem_q[w_ridx];
                rresp_q   <= w_ar_oor ? 2'b10 : 2'b00;
            end else if (arvalid_q && !rvalid_q && !arready_q) begin
                arready_q <= 1'b1;
            end
        end
    end

    assign ready   = ready_q;
    assign AWVALID = awvalid_q;
    assign AWREADY = awready_q;
    assign WVALID  = wvalid_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BREADY  = bready_q;
    assign ARVALID = arvalid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RREADY  = rready_q;
    assign AWADDR  = awaddr_q;
    assign WDATA   = wdata_q;
    assign ARADDR  = araddr_q;
    assign WSTRB   = wstrb_q;
    assign BRESP   = bresp_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master_slave.sv
// tb_axi_lite_master_slave: directed test-plan sequences plus randomized requests against a transaction-level model.
`default_nettype none

module tb_axi_lite_master_slave;
    localparam int DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic        valid = 1'b0, read_valid = 1'b0;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [3:0]  w_strb = '0;
    logic        ready, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi_lite_master_slave #(.DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .valid(valid), .read_valid(read_valid),
        .aw_addr(aw_addr), .w_data(w_data), .w_strb(w_strb), .ar_addr(ar_addr),
        .ready(ready), .AWVALID(AWVALID), .AWREADY(AWREADY), .WVALID(WVALID),
        .WREADY(WREADY), .BVALID(BVALID), .BREADY(BREADY), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RVALID(RVALID), .RREADY(RREADY), .AWADDR(AWADDR),
        .WDATA(WDATA), .ARADDR(ARADDR), .WSTRB(WSTRB), .BRESP(BRESP),
        .RRESP(RRESP), .RDATA(RDATA)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase = edges since the request was accepted (-1 idle).
    int          m_ph = -1;
    bit          m_w = 1'b0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic bit oor(input logic [31:0] a);
`ifdef AXI_ADDR_CHECK_EN
        return a >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            m_ph = -1;
            m_awaddr = 0; m_wdata = 0; m_wstrb = 0; m_araddr = 0;
            m_rdata = 0; m_bresp = 0; m_rresp = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else if (m_ph < 0) begin
            if (valid) begin
                m_w = 1'b1; m_awaddr = aw_addr; m_wdata = w_data; m_wstrb = w_strb; m_ph = 0;
            end else if (read_valid) begin
                m_w = 1'b0; m_araddr = ar_addr; m_ph = 0;
            end
        end else if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            m_ph = 2;
            if (m_w) begin
                m_bresp = oor(m_awaddr) ? 2'b10 : 2'b00;
                if (!oor(m_awaddr))
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_mem[m_awaddr % DEPTH][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
                m_rresp = oor(m_araddr) ? 2'b10 : 2'b00;
                m_rdata = oor(m_araddr) ? 32'h0 : m_mem[m_araddr % DEPTH];
            end
        end else begin
            m_ph = -1;
        end
    end

    always @(negedge ACLK) begin
        if (ARESET) begin
            chk("ready",   ready,   m_ph < 0);
            chk("AWVALID", AWVALID, m_w && (m_ph == 0 || m_ph == 1));
            chk("WVALID",  WVALID,  m_w && (m_ph == 0 || m_ph == 1));
            chk("AWREADY", AWREADY, m_w && m_ph == 1);
            chk("WREADY",  WREADY,  m_w && m_ph == 1);
            chk("BVALID",  BVALID,  m_w && m_ph == 2);
            chk("BREADY",  BREADY,  m_w && m_ph == 2);
            chk("ARVALID", ARVALID, !m_w && (m_ph == 0 || m_ph == 1));
            chk("ARREADY", ARREADY, !m_w && m_ph == 1);
            chk("RVALID",  RVALID,  !m_w && m_ph == 2);
            chk("RREADY",  RREADY,  !m_w && m_ph == 2);
            chk("AWADDR",  AWADDR,  m_awaddr);
            chk("WDATA",   WDATA,   m_wdata);
            chk("WSTRB",   WSTRB,   m_wstrb);
            chk("ARADDR",  ARADDR,  m_araddr);
            chk("BRESP",   BRESP,   m_bresp);
            chk("RRESP",   RRESP,   m_rresp);
            chk("RDATA",   RDATA,   m_rdata);
        end
    end

    // Both tasks start 1 ns after an edge with the master idle and return 1 ns after edge N+3.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] br);
        valid = 1'b1; aw_addr = a; w_data = d; w_strb = s;
        @(posedge ACLK); #1; valid = 1'b0;
        @(posedge ACLK); @(posedge ACLK); #1;
        chk("wr_bvalid_n2", BVALID, 1);
        br = BRESP;
        @(posedge ACLK); #1;
        chk("wr_ready_n3", ready, 1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] rr);
        read_valid = 1'b1; ar_addr = a;
        @(posedge ACLK); #1; read_valid = 1'b0;
        @(posedge ACLK); @(posedge ACLK); #1;
        chk("rd_rvalid_n2", RVALID, 1);
        d = RDATA; rr = RRESP;
        @(posedge ACLK); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    logic [31:0] rd;
    logic [1:0]  rsp;

    initial begin
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_handshakes", {AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY,
                               ARVALID, ARREADY, RVALID, RREADY}, 0);
        chk("rst_rdata", RDATA, 0);
        #8; ARESET = 1'b1;
        @(posedge ACLK); #1;

        do_write(0, 32'h12345678, 4'b0001, rsp); chk("w0_bresp", rsp, 2'b00);
        do_read(0, rd, rsp); chk("r0_data", rd, 32'h00000078); chk("r0_resp", rsp, 2'b00);

        do_write(1, 32'h12345678, 4'b0011, rsp);
        do_write(3, 32'h12345678, 4'b1101, rsp);
        do_write(7, 32'h12345678, 4'b1111, rsp);
        do_read(1, rd, rsp); chk("r1_data", rd, 32'h00005678); chk("r1_resp", rsp, 2'b00);
        do_read(3, rd, rsp); chk("r3_data", rd, 32'h12340078);
        do_read(7, rd, rsp); chk("r7_data", rd, 32'h12345678);

        // Simultaneous write and read request: write wins.
        valid = 1'b1; read_valid = 1'b1; aw_addr = 2; w_data = 32'h0BADF00D; w_strb = 4'hF; ar_addr = 0;
        @(posedge ACLK); #1; valid = 1'b0; read_valid = 1'b0;
        chk("both_arvalid", ARVALID, 0); chk("both_awvalid", AWVALID, 1);
        repeat (3) @(posedge ACLK); #1;
        do_read(2, rd, rsp); chk("both_r2", rd, 32'h0BADF00D);

        // Write request pulsed while busy is ignored.
        valid = 1'b1; aw_addr = 5; w_data = 32'hAAAA5555; w_strb = 4'hF;
        @(posedge ACLK); #1; valid = 1'b0;
        @(posedge ACLK); #1; valid = 1'b1; aw_addr = 6; w_data = 32'hDEADBEEF;
        @(posedge ACLK); #1; valid = 1'b0;
        chk("busy_awaddr", AWADDR, 5);
        @(posedge ACLK); #1;
        do_read(6, rd, rsp); chk("busy_r6", rd, 32'h0);
        do_read(5, rd, rsp); chk("busy_r5", rd, 32'hAAAA5555);

        do_write(20, 32'hCAFEBABE, 4'hF, rsp);
`ifdef AXI_ADDR_CHECK_EN
        chk("oor_bresp", rsp, 2'b10);
        do_read(4, rd, rsp);  chk("oor_r4", rd, 32'h0);
        do_read(20, rd, rsp); chk("oor_r20_data", rd, 32'h0); chk("oor_r20_resp", rsp, 2'b10);
`else
        chk("wrap_bresp", rsp, 2'b00);
        do_read(4, rd, rsp);  chk("wrap_r4", rd, 32'hCAFEBABE);
        do_read(20, rd, rsp); chk("wrap_r20_data", rd, 32'hCAFEBABE); chk("wrap_r20_resp", rsp, 2'b00);
`endif

        // Random requests every cycle; the model decides which ones are accepted.
        for (int c = 0; c < 1500; c++) begin
            valid      = ($urandom_range(0, 3) == 0);
            read_valid = ($urandom_range(0, 2) == 0);
            aw_addr    = rand_addr();
            ar_addr    = rand_addr();
            w_data     = $urandom;
            w_strb     = 4'($urandom_range(0, 15));
            @(posedge ACLK); #1;
        end
        valid = 1'b0; read_valid = 1'b0;
        repeat (4) @(posedge ACLK); #1;

        // Reset asserted while BVALID is high.
        valid = 1'b1; aw_addr = 9; w_data = 32'h55AA55AA; w_strb = 4'hF;
        @(posedge ACLK); #1; valid = 1'b0;
        @(posedge ACLK); @(posedge ACLK); #1;
        chk("pre_rst_bvalid", BVALID, 1);
        ARESET = 1'b0; #1;
        chk("mid_rst_handshakes", {AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY,
                                   ARVALID, ARREADY, RVALID, RREADY}, 0);
        chk("mid_rst_ready", ready, 1);
        #2; ARESET = 1'b1;
        @(posedge ACLK); #1;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i, rd, rsp);
            chk("post_rst_mem", rd, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
